ov7670_blob_scanner: RTL and testbench

//  Downstream consumer of the OV7670 binarized ping-pong frame buffer.
//  On a Start pulse it sweeps the buffer's read port once (raster order,
//  one pixel per Clock) and measures the white (1) pixels: pixel count and

---
 rtl/ov7670_blob_scanner_if.sv | 31 +++
 rtl/ov7670_blob_scanner.sv | 151 +++++++++++++++
 tb/tb_ov7670_blob_scanner.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/ov7670_blob_scanner_if.sv
// Scanner-side bus: start handshake, frame-buffer read port and results.
interface ov7670_blob_scanner_if #(
    parameter int ADDR_W = 19,
    parameter int XW     = 10,
    parameter int YW     = 9
);
    logic              Start;
    logic              Read;
    logic [ADDR_W-1:0] ReadAddr;
    logic              BufferData;
    logic              Busy;
    logic              Done;
    logic              Valid;
    logic [ADDR_W-1:0] PixelCount;
    logic [XW-1:0]     XMin, XMax;
    logic [YW-1:0]     YMin, YMax;

    // scanner side
    modport master (
        input  Start, BufferData,
        output Read, ReadAddr, Busy, Done, Valid, PixelCount,
               XMin, XMax, YMin, YMax
    );

    // controller / buffer side
    modport slave (
        output Start, BufferData,
        input  Read, ReadAddr, Busy, Done, Valid, PixelCount,
               XMin, XMax, YMin, YMax
    );
endinterface

// File: rtl/ov7670_blob_scanner.sv
// Sweeps the binarized frame buffer once per Start and reports the white
// pixel count and bounding box of the frame.
module ov7670_blob_scanner #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    parameter int ADDR_W = 19,
    parameter int XW     = 10,
    parameter int YW     = 9,
    parameter int RD_LAT = 1
) (
    input  logic                   Clock,
    input  logic                   Reset,
    ov7670_blob_scanner_if.master  bus
);
    localparam int DW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;
    state_t state, state_nxt;

    logic [XW-1:0]     x;
    logic [YW-1:0]     y;
    logic [ADDR_W-1:0] addr;
    logic [DW-1:0]     drain_cnt;
    logic              last_issue, drain_last, issue;

    // coordinates travel alongside the read so each sample meets its own x/y
    logic              vld_pipe [1:RD_LAT];
    logic [XW-1:0]     x_pipe   [1:RD_LAT];
    logic [YW-1:0]     y_pipe   [1:RD_LAT];

    logic              smp;
    logic [XW-1:0]     sx;
    logic [YW-1:0]     sy;
    logic [ADDR_W-1:0] cnt, cnt_nxt;
    logic [XW-1:0]     xmin, xmax, xmin_nxt, xmax_nxt;
    logic [YW-1:0]     ymin, ymax, ymin_nxt, ymax_nxt;

    logic              res_valid;
    logic [ADDR_W-1:0] res_cnt;
    logic [XW-1:0]     res_xmin, res_xmax;
    logic [YW-1:0]     res_ymin, res_ymax;

    assign last_issue = (x == XW'(WIDTH - 1)) && (y == YW'(HEIGHT - 1));
    assign drain_last = (drain_cnt == DW'(RD_LAT - 1));
    assign issue      = (state == SCAN);

    assign smp = vld_pipe[RD_LAT] & bus.BufferData;
    assign sx  = x_pipe[RD_LAT];
    assign sy  = y_pipe[RD_LAT];

    // state register
    always_ff @(posedge Clock) begin
        if (Reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // next-state: one pass of the frame, drain the read latency, report
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.Start) state_nxt = SCAN;
            SCAN:    if (last_issue) state_nxt = DRAIN;
            DRAIN:   if (drain_last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // accumulator update for the sample arriving this cycle
    always_comb begin
        cnt_nxt  = cnt + ADDR_W'(smp);
        xmin_nxt = (smp && sx < xmin) ? sx : xmin;
        xmax_nxt = (smp && sx > xmax) ? sx : xmax;
        ymin_nxt = (smp && sy < ymin) ? sy : ymin;
        ymax_nxt = (smp && sy > ymax) ? sy : ymax;
    end

    // alignment pipeline for issued coordinates
    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int i = 1; i <= RD_LAT; i++) begin
                vld_pipe[i] <= 1'b0;
                x_pipe[i]   <= '0;
                y_pipe[i]   <= '0;
            end
        end else begin
            vld_pipe[1] <= issue;
            x_pipe[1]   <= x;
            y_pipe[1]   <= y;
            for (int i = 2; i <= RD_LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                x_pipe[i]   <= x_pipe[i-1];
                y_pipe[i]   <= y_pipe[i-1];
            end
        end
    end

    // raster address generator, accumulators and drain counter
    always_ff @(posedge Clock) begin
        if (Reset) begin
            x <= '0; y <= '0; addr <= '0; drain_cnt <= '0;
            cnt <= '0; xmin <= '1; xmax <= '0; ymin <= '1; ymax <= '0;
        end else begin
            drain_cnt <= (state == DRAIN) ? drain_cnt + DW'(1) : '0;
            if (state == IDLE && bus.Start) begin
                x <= '0; y <= '0; addr <= '0;
                cnt <= '0; xmin <= '1; xmax <= '0; ymin <= '1; ymax <= '0;
            end else begin
                cnt <= cnt_nxt; xmin <= xmin_nxt; xmax <= xmax_nxt;
                ymin <= ymin_nxt; ymax <= ymax_nxt;
                // address holds on the last pixel through DRAIN
                if (state == SCAN && !last_issue) begin
                    addr <= addr + ADDR_W'(1);
                    if (x == XW'(WIDTH - 1)) begin
                        x <= '0;
                        y <= y + YW'(1);
                    end else begin
                        x <= x + XW'(1);
                    end
                end
            end
        end
    end

    // results load on entry to DONE from the final accumulator values,
    // so they are already visible during the Done pulse
    always_ff @(posedge Clock) begin
        if (Reset) begin
            res_valid <= 1'b0; res_cnt <= '0;
            res_xmin <= '0; res_xmax <= '0; res_ymin <= '0; res_ymax <= '0;
        end else if (state == DRAIN && drain_last) begin
            res_valid <= (cnt_nxt != '0);
            res_cnt   <= cnt_nxt;
            res_xmin  <= (cnt_nxt != '0) ? xmin_nxt : '0;
            res_xmax  <= (cnt_nxt != '0) ? xmax_nxt : '0;
            res_ymin  <= (cnt_nxt != '0) ? ymin_nxt : '0;
            res_ymax  <= (cnt_nxt != '0) ? ymax_nxt : '0;
        end
    end

    assign bus.Read       = (state == SCAN) || (state == DRAIN);
    assign bus.Busy       = (state != IDLE);
    assign bus.Done       = (state == DONE);
    assign bus.ReadAddr   = addr;
    assign bus.Valid      = res_valid;
    assign bus.PixelCount = res_cnt;
    assign bus.XMin       = res_xmin;
    assign bus.XMax       = res_xmax;
    assign bus.YMin       = res_ymin;
    assign bus.YMax       = res_ymax;
endmodule

// File: tb/tb_ov7670_blob_scanner.sv
// Directed bench: 8x4 frame, registered-read buffer model, plus an RD_LAT=2
// instance sharing the same frame memory.
module tb_ov7670_blob_scanner;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ov7670_blob_scanner_if #(.ADDR_W(5), .XW(3), .YW(2)) b0 ();
    ov7670_blob_scanner_if #(.ADDR_W(5), .XW(3), .YW(2)) b1 ();

    ov7670_blob_scanner #(.WIDTH(8), .HEIGHT(4), .ADDR_W(5), .XW(3), .YW(2), .RD_LAT(1))
        u0 (.Clock(clk), .Reset(rst), .bus(b0));
    ov7670_blob_scanner #(.WIDTH(8), .HEIGHT(4), .ADDR_W(5), .XW(3), .YW(2), .RD_LAT(2))
        u1 (.Clock(clk), .Reset(rst), .bus(b1));

    logic mem [0:31];
    logic r1a;

    // frame buffer read ports: 1-cycle and 2-cycle latency
    always @(posedge clk) begin
        b0.BufferData <= mem[b0.ReadAddr];
        r1a           <= mem[b1.ReadAddr];
        b1.BufferData <= r1a;
    end

    int errs = 0;
    int checks = 0;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    int r_valid, r_cnt, r_xmin, r_xmax, r_ymin, r_ymax;

    task automatic clear_mem();
        for (int i = 0; i < 32; i++) mem[i] = 1'b0;
    endtask

    // one sweep, observed for a fixed window; optional extra Start pulses
    task automatic sweep(input bit sel, input bit pulse_mid,
                         output int lat, output int rd, output int dones);
        lat = 0; rd = 0; dones = 0;
        @(negedge clk);
        if (sel) b1.Start = 1'b1; else b0.Start = 1'b1;
        for (int n = 1; n <= 45; n++) begin
            @(negedge clk);
            b0.Start = pulse_mid && (n == 5 || n == 20 || n == 34);
            b1.Start = 1'b0;
            if (sel ? b1.Read : b0.Read) rd++;
            if (sel ? b1.Done : b0.Done) begin
                dones++;
                if (lat == 0) begin
                    lat = n;
                    r_valid = sel ? int'(b1.Valid)      : int'(b0.Valid);
                    r_cnt   = sel ? int'(b1.PixelCount) : int'(b0.PixelCount);
                    r_xmin  = sel ? int'(b1.XMin)       : int'(b0.XMin);
                    r_xmax  = sel ? int'(b1.XMax)       : int'(b0.XMax);
                    r_ymin  = sel ? int'(b1.YMin)       : int'(b0.YMin);
                    r_ymax  = sel ? int'(b1.YMax)       : int'(b0.YMax);
                end
            end
        end
        b0.Start = 1'b0;
        if (lat == 0) chk("done_timeout", 0, 1);
    endtask

    task automatic chk_box(input string tag, input int v, input int c,
                           input int x0, input int x1, input int y0, input int y1);
        chk({tag, "_valid"}, r_valid, v);
        chk({tag, "_count"}, r_cnt, c);
        chk({tag, "_xmin"}, r_xmin, x0);
        chk({tag, "_xmax"}, r_xmax, x1);
        chk({tag, "_ymin"}, r_ymin, y0);
        chk({tag, "_ymax"}, r_ymax, y1);
    endtask

    int lat, rd, dn;

    initial begin
        b0.Start = 1'b0;
        b1.Start = 1'b0;
        clear_mem();
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // 1: idle after reset
        repeat (10) @(negedge clk);
        chk("rst_read", b0.Read, 0);
        chk("rst_addr", b0.ReadAddr, 0);
        chk("rst_busy", b0.Busy, 0);
        chk("rst_done", b0.Done, 0);
        chk("rst_valid", b0.Valid, 0);
        chk("rst_count", b0.PixelCount, 0);
        chk("rst_box", {b0.XMin, b0.XMax, b0.YMin, b0.YMax}, 0);

        // 2: empty frame
        sweep(0, 0, lat, rd, dn);
        chk("empty_lat", lat, 34);
        chk_box("empty", 0, 0, 0, 0, 0, 0);

        // 3: three pixels
        mem[10] = 1'b1; mem[13] = 1'b1; mem[27] = 1'b1;
        sweep(0, 0, lat, rd, dn);
        chk("three_lat", lat, 34);
        chk("three_reads", rd, 33);
        chk_box("three", 1, 3, 2, 5, 1, 3);
        chk("three_hold", b0.PixelCount, 3);
        chk("three_hold_xmax", b0.XMax, 5);

        // RD_LAT=2 rerun of the same frame
        sweep(1, 0, lat, rd, dn);
        chk("lat2_lat", lat, 35);
        chk("lat2_reads", rd, 34);
        chk_box("lat2", 1, 3, 2, 5, 1, 3);

        // 4: corners
        clear_mem(); mem[0] = 1'b1;
        sweep(0, 0, lat, rd, dn);
        chk_box("first", 1, 1, 0, 0, 0, 0);
        clear_mem(); mem[31] = 1'b1;
        sweep(0, 0, lat, rd, dn);
        chk_box("last", 1, 1, 7, 7, 3, 3);

        // 5: Start pulses while busy and in DONE are ignored
        clear_mem();
        mem[10] = 1'b1; mem[13] = 1'b1; mem[27] = 1'b1;
        sweep(0, 1, lat, rd, dn);
        chk("busy_dones", dn, 1);
        chk("busy_reads", rd, 33);
        chk("busy_lat", lat, 34);
        chk("busy_count", r_cnt, 3);

        // 6: reset mid-sweep
        @(negedge clk); b0.Start = 1'b1;
        @(negedge clk); b0.Start = 1'b0;
        repeat (9) @(negedge clk);
        chk("pre_rst_read", b0.Read, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_read", b0.Read, 0);
        chk("abort_busy", b0.Busy, 0);
        chk("abort_valid", b0.Valid, 0);
        chk("abort_count", b0.PixelCount, 0);
        chk("abort_box", {b0.XMin, b0.XMax, b0.YMin, b0.YMax}, 0);
        rst = 1'b0;
        @(negedge clk);
        sweep(0, 0, lat, rd, dn);
        chk("after_lat", lat, 34);
        chk_box("after", 1, 3, 2, 5, 1, 3);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
